fetch_queue_stage: RTL
======================

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, program-counter and address width in bits (>=8).
REQ-002 The block SHALL have parameter INSTR_W, default 32, instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port pc_src_e  input  1  execute-stage redirect request.
REQ-008 The block SHALL have port pc_target_e  input  PC_W  redirect target address.
REQ-009 The block SHALL have port stall_d  input  1  decode not accepting this cycle.
REQ-010 The block SHALL have port imem_addr  output  PC_W  instruction-memory address (current PC).
REQ-011 The block SHALL have port imem_en  output  1  fetch fires this cycle.
REQ-012 The block SHALL have port imem_rdata  input  INSTR_W  combinational instruction-memory read data for imem_addr.
REQ-013 The block SHALL have port instr_d  output  INSTR_W  queue-head instruction.
REQ-014 The block SHALL have port pc_d  output  PC_W  queue-head PC.
REQ-015 The block SHALL have port pc_plus4_d  output  PC_W  queue-head PC+4.
REQ-016 The block SHALL have port valid_d  output  1  queue head holds a valid entry.
REQ-017 The block SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 The block SHALL hold a PC register; imem_addr SHALL equal the PC at all times.
REQ-019 The queue SHALL be a circular buffer of DEPTH entries {instr, pc, pc+4}, with read/write pointers wrapping modulo DEPTH.
REQ-020 pop SHALL be defined as valid_d & ~stall_d & ~pc_src_e.
REQ-021 push (imem_en) SHALL be defined as ~pc_src_e & (count<DEPTH | pop).
REQ-022 On push, the block SHALL write {imem_rdata, PC, PC+4} at the write pointer and advance PC to PC+4 on the same edge.
REQ-023 PC arithmetic SHALL be modulo 2^PC_W; PC+4 from all-ones-minus-3 SHALL wrap to 0.
REQ-024 On pop, the read pointer SHALL advance; simultaneous push and pop SHALL leave count unchanged.
REQ-025 When full with no pop, there SHALL be no push, the PC SHALL hold, and the queue SHALL be unchanged.
REQ-026 When empty, valid_d SHALL be 0 and stall_d SHALL be ignored.
REQ-027 When pc_src_e=1, the redirect SHALL take priority: the next edge SHALL empty the queue (count=0, pointers equal), load PC<=pc_target_e, and perform no push or pop.
REQ-028 After a redirect edge, the first fetch at the target SHALL occur on the following edge, with valid_d=1 one edge later (redirect-to-valid latency 2 edges).
REQ-029 instr_d, pc_d and pc_plus4_d SHALL be read combinationally from the head entry and SHALL be don't-care when valid_d=0.
REQ-030 Fetch-to-decode latency SHALL be 1 edge: an instruction fetched on edge N SHALL be visible at the head after edge N if the queue was empty.
REQ-031 valid_d SHALL equal (count!=0).

Reset
REQ-032 While rst=0, the block SHALL hold PC=RESET_PC, pointers=0, count=0, valid_d=0, and all entry storage cleared to 0, asynchronously.
REQ-033 Assertion of rst mid-operation SHALL discard all queue contents and any pending redirect immediately.
REQ-034 imem_en SHALL follow its combinational definition during reset; no state SHALL change while rst=0.
REQ-035 The first push after release SHALL occur on the first rising edge with rst=1, at address RESET_PC.

Verification
REQ-036 The bench SHALL cover reset release with stall_d=0, DEPTH=4, and memory returning (addr>>2): valid_d=1 after edge 1 with pc_d=0, instr_d=0, and consecutive pc_d 0,4,8,... every cycle, count steady at 1.
REQ-037 The bench SHALL cover stall_d=1 held: count reaches 4 after 4 edges, PC holds at 16, imem_en=0, and head stays at pc_d=0.
REQ-038 The bench SHALL cover the full queue with stall_d dropped for one cycle: a simultaneous push and pop occurs, count stays 4, and the head advances to pc_d=4.
REQ-039 The bench SHALL cover pc_src_e=1 with pc_target_e=0x100 while count=3: next edge gives count=0 and valid_d=0; one edge later pc_d=0x100 and pc_plus4_d=0x104.
REQ-040 The bench SHALL cover PC_W=8 with a redirect to 0xFC: fetches occur at 0xFC then 0x00, and pc_plus4_d for the 0xFC entry is 0x00.
REQ-041 The bench SHALL cover rst asserted mid-stream with count=2: outputs go to valid_d=0, count=0 and imem_addr=RESET_PC before the next edge.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC register feeding a circular fetch queue.
// Execute-stage redirects flush the queue and reload the PC.

module fetch_queue_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  logic [W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (we) data_d = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign rdata = data_q;

endmodule

module fetch_queue_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_src_e,
  input  logic [PC_W-1:0]          pc_target_e,
  input  logic                     stall_d,
  output logic [PC_W-1:0]          imem_addr,
  output logic                     imem_en,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic [INSTR_W-1:0]       instr_d,
  output logic [PC_W-1:0]          pc_d,
  output logic [PC_W-1:0]          pc_plus4_d,
  output logic                     valid_d,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc4;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_d, fetch_pc_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;

  logic             push, pop;
  logic [PC_W-1:0]  fetch_pc_plus4;
  entry_t           wr_entry;
  entry_t           head;
  entry_t [DEPTH-1:0] ent_q;

  // Redirect squashes both ends of the queue in the same cycle.
  assign pop            = valid_d & ~stall_d & ~pc_src_e;
  assign push           = ~pc_src_e & ((count_q < CNT_W'(DEPTH)) | pop);
  assign fetch_pc_plus4 = fetch_pc_q + PC_W'(4);

  assign wr_entry = '{instr: imem_rdata, pc: fetch_pc_q, pc4: fetch_pc_plus4};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    fetch_queue_entry #(.W($bits(entry_t))) u_ent (
      .clk   (clk),
      .rst   (rst),
      .we    (push && (wr_ptr_q == PTR_W'(i))),
      .wdata (wr_entry),
      .rdata (ent_q[i])
    );
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (pc_src_e) begin
      fetch_pc_d = pc_target_e;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_plus4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head       = ent_q[rd_ptr_q];
  assign imem_addr  = fetch_pc_q;
  assign imem_en    = push;
  assign instr_d    = head.instr;
  assign pc_d       = head.pc;
  assign pc_plus4_d = head.pc4;
  assign valid_d    = (count_q != '0);
  assign count      = count_q;

endmodule
